// File: rtl/npu_bus_arbiter.sv
// Shared NPU data-bus arbiter: the host has fixed top priority and the PEs are served round-robin.
// Tenures have a bounded length, and idle turnaround cycles separate one driver from the next.
module npu_bus_arbiter #(
   parameter int unsigned NUM_PE     = 8,
   parameter int unsigned TURNAROUND = 1,
   parameter int unsigned MAX_BEATS  = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              host_req,
   input  logic              host_last,
   input  logic [NUM_PE-1:0] pe_req,
   input  logic [NUM_PE-1:0] pe_last,
   output logic              host_gnt,
   output logic [NUM_PE-1:0] pe_oe,
   output logic              gnt_valid,
   output logic [3:0]        gnt_id,
   output logic              timeout,
   output logic              bus_busy
);

   localparam int unsigned IDX_W  = 3;
   localparam int unsigned BEAT_W = 6;
   localparam int unsigned TURN_W = 2;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);
   localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(TURNAROUND - 1);
   localparam logic [3:0]        HOST_ID   = 4'b1000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_GRANT,
      ST_TURN
   } state_e;

   state_e             state_q,    state_d;
   logic               host_gnt_q, host_gnt_d;
   logic [NUM_PE-1:0]  pe_oe_q,    pe_oe_d;
   logic               gnt_valid_q, gnt_valid_d;
   logic [3:0]         gnt_id_q,   gnt_id_d;
   logic               timeout_q,  timeout_d;
   logic               bus_busy_q, bus_busy_d;
   logic [IDX_W-1:0]   rr_ptr_q,   rr_ptr_d;
   logic [BEAT_W-1:0]  beat_cnt_q, beat_cnt_d;
   logic [TURN_W-1:0]  turn_cnt_q, turn_cnt_d;

   logic               pe_hit;
   logic [IDX_W-1:0]   pe_sel;
   logic [IDX_W-1:0]   cand;
   logic [IDX_W-1:0]   cur_idx;
   logic               cur_req;
   logic               cur_last;

   // Round-robin search starting at rr_ptr; the 3-bit index wraps modulo 8 by itself.
   always_comb begin
      // NOTE: every combinational output gets a default before any branch, so no latch can be inferred.
      pe_hit = 1'b0;
      pe_sel = '0;
      cand   = '0;
      for (int k = 0; k < NUM_PE; k++) begin
         cand = rr_ptr_q + IDX_W'(k);
         if (!pe_hit && pe_req[cand]) begin
            pe_hit = 1'b1;
            pe_sel = cand;
         end
      end
   end

   // Only the granted requester's req/last can influence the running tenure.
   always_comb begin
      cur_idx  = gnt_id_q[IDX_W-1:0];
      cur_req  = host_gnt_q ? host_req  : pe_req[cur_idx];
      cur_last = host_gnt_q ? host_last : pe_last[cur_idx];
   end

   always_comb begin
      state_d    = state_q;
      host_gnt_d = host_gnt_q;
      pe_oe_d    = pe_oe_q;
      gnt_id_d   = gnt_id_q;
      rr_ptr_d   = rr_ptr_q;
      beat_cnt_d = beat_cnt_q;
      turn_cnt_d = turn_cnt_q;
      timeout_d  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (host_req) begin
               state_d    = ST_GRANT;
               host_gnt_d = 1'b1;
               gnt_id_d   = HOST_ID;
               beat_cnt_d = '0;
            end else if (pe_hit) begin
               state_d          = ST_GRANT;
               pe_oe_d          = '0;
               pe_oe_d[pe_sel]  = 1'b1;
               gnt_id_d         = {1'b0, pe_sel};
               rr_ptr_d         = pe_sel + IDX_W'(1);
               beat_cnt_d       = '0;
            end
         end

         ST_GRANT: begin
            if (!cur_req || cur_last || (beat_cnt_q == LAST_BEAT)) begin
               state_d    = ST_TURN;
               host_gnt_d = 1'b0;
               pe_oe_d    = '0;
               turn_cnt_d = '0;
               // The limit only counts as a timeout when no normal release or abort coincides with it.
               timeout_d  = cur_req && !cur_last;
            end else begin
               beat_cnt_d = beat_cnt_q + BEAT_W'(1);
            end
         end

         ST_TURN: begin
            if (turn_cnt_q == LAST_TURN) begin
               state_d = ST_IDLE;
            end else begin
               turn_cnt_d = turn_cnt_q + TURN_W'(1);
            end
         end

         default: begin
            state_d    = ST_IDLE;
            host_gnt_d = 1'b0;
            pe_oe_d    = '0;
         end
      endcase

      gnt_valid_d = host_gnt_d | (|pe_oe_d);
      bus_busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         host_gnt_q  <= 1'b0;
         pe_oe_q     <= '0;
         gnt_valid_q <= 1'b0;
         gnt_id_q    <= '0;
         timeout_q   <= 1'b0;
         bus_busy_q  <= 1'b0;
         rr_ptr_q    <= '0;
         beat_cnt_q  <= '0;
         turn_cnt_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments, so every register updates from values sampled before the edge.
         state_q     <= state_d;
         host_gnt_q  <= host_gnt_d;
         pe_oe_q     <= pe_oe_d;
         gnt_valid_q <= gnt_valid_d;
         gnt_id_q    <= gnt_id_d;
         timeout_q   <= timeout_d;
         bus_busy_q  <= bus_busy_d;
         rr_ptr_q    <= rr_ptr_d;
         beat_cnt_q  <= beat_cnt_d;
         turn_cnt_q  <= turn_cnt_d;
      end
   end

   assign host_gnt  = host_gnt_q;
   assign pe_oe     = pe_oe_q;
   assign gnt_valid = gnt_valid_q;
   assign gnt_id    = gnt_id_q;
   assign timeout   = timeout_q;
   assign bus_busy  = bus_busy_q;

endmodule
